// File: rtl/tmds_decoder.sv
// -----------------------------------------------------------------------------
// tmds_decoder
//
// Per-channel TMDS receive decoder and word aligner for the DVI input path.
// Takes the 10-bit word delivered each pixel clock by an external 1:10
// deserializer and drives that deserializer's bitslip until runs of control
// tokens during blanking show that words are correctly framed. Once framed,
// every word is decoded to an 8-bit pixel byte or a 2-bit control code and
// lock is reported.
//
// Parameters:
//   CTRL_RUN       consecutive control tokens that prove alignment
//   SEARCH_TIMEOUT cycles without a qualifying run before a slip (searching)
//                  or before lock is dropped (locked); must exceed one line
//   SLIP_WAIT      settle cycles after each bitslip pulse
//
// Ports:
//   clk_i      in   1  pixel clock (deserializer CLKDIV)
//   rst_i      in   1  asynchronous active-high reset
//   raw_i      in  10  deserialized word, raw_i[0] is first on the wire
//   bitslip_o  out  1  one-cycle bitslip request to the deserializer
//   lock_o     out  1  word alignment established
//   data_o     out  8  decoded pixel byte
//   ctrl_o     out  2  decoded control bits {c1,c0}
//   de_o       out  1  data enable (word is not a control token)
//
// All outputs are registered; decode latency is one clock. While not locked,
// data_o, ctrl_o and de_o are held at zero.
// -----------------------------------------------------------------------------
module tmds_decoder #(
    parameter int CTRL_RUN       = 32,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int SLIP_WAIT      = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [9:0] raw_i,
    output logic       bitslip_o,
    output logic       lock_o,
    output logic [7:0] data_o,
    output logic [1:0] ctrl_o,
    output logic       de_o
);

    localparam int RUN_W  = $clog2(CTRL_RUN + 1);
    localparam int TO_W   = $clog2(SEARCH_TIMEOUT + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(CTRL_RUN);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(SEARCH_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    // Returns {is_token, c1, c0}; anything that is not one of the four DVI
    // control tokens is treated as pixel data.
    function automatic logic [2:0] token_match(input logic [9:0] raw);
        logic [2:0] res;
        case (raw)
            10'b1101010100: res = 3'b100;
            10'b0010101011: res = 3'b101;
            10'b0101010100: res = 3'b110;
            10'b1010101011: res = 3'b111;
            default:        res = 3'b000;
        endcase
        return res;
    endfunction

    // TMDS data decode: undo the optional inversion (bit 9), then undo the
    // XOR/XNOR transition chain selected by bit 8.
    function automatic logic [7:0] tmds_decode(input logic [9:0] raw);
        logic [7:0] m;
        logic [7:0] d;
        m    = raw[9] ? ~raw[7:0] : raw[7:0];
        d[0] = m[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = raw[8] ? (m[i] ^ m[i-1]) : ~(m[i] ^ m[i-1]);
        end
        return d;
    endfunction

    state_t              state_r;
    state_t              state_s;
    logic [RUN_W-1:0]    run_r;
    logic [RUN_W-1:0]    run_s;
    logic [RUN_W-1:0]    run_step_s;
    logic [TO_W-1:0]     to_r;
    logic [TO_W-1:0]     to_s;
    logic [WAIT_W-1:0]   wait_r;
    logic [WAIT_W-1:0]   wait_s;

    logic [2:0]          tok_match_s;
    logic                is_tok_s;
    logic [1:0]          tok_ctrl_s;
    logic [7:0]          dec_data_s;

    logic                bitslip_r;
    logic                lock_r;
    logic [7:0]          data_r;
    logic [1:0]          ctrl_r;
    logic                de_r;
    logic                bitslip_s;
    logic                lock_s;
    logic [7:0]          data_s;
    logic [1:0]          ctrl_s;
    logic                de_s;

    assign tok_match_s = token_match(raw_i);
    assign is_tok_s    = tok_match_s[2];
    assign tok_ctrl_s  = tok_match_s[1:0];
    assign dec_data_s  = tmds_decode(raw_i);

    // Run length of consecutive control tokens including the current word,
    // saturating so a long blanking interval keeps reporting a full run.
    always_comb begin
        run_step_s = '0;
        if (is_tok_s) begin
            if (run_r == RUN_MAX) begin
                run_step_s = RUN_MAX;
            end else begin
                run_step_s = run_r + RUN_W'(1);
            end
        end else begin
            run_step_s = '0;
        end
    end

    // Alignment FSM next-state and counter updates.
    always_comb begin
        state_s = state_r;
        run_s   = run_r;
        to_s    = to_r;
        wait_s  = wait_r;
        case (state_r)
            ST_SEARCH: begin
                run_s = run_step_s;
                // A completed run takes priority over a coincident timeout.
                if (run_step_s == RUN_MAX) begin
                    state_s = ST_LOCKED;
                    to_s    = '0;
                end else if (to_r == TO_LAST) begin
                    state_s = ST_SLIP;
                    run_s   = '0;
                    to_s    = '0;
                end else begin
                    to_s = to_r + TO_W'(1);
                end
            end
            ST_SLIP: begin
                state_s = ST_WAIT;
                run_s   = '0;
                to_s    = '0;
                wait_s  = '0;
            end
            ST_WAIT: begin
                // raw_i is ignored here: the deserializer output is still
                // settling after the slip.
                if (wait_r == WAIT_LAST) begin
                    state_s = ST_SEARCH;
                    run_s   = '0;
                    to_s    = '0;
                    wait_s  = '0;
                end else begin
                    wait_s = wait_r + WAIT_W'(1);
                end
            end
            ST_LOCKED: begin
                run_s = run_step_s;
                // Any cycle that still shows a full run restarts the
                // watchdog; otherwise drop lock quietly after the timeout
                // (no slip, the framing was good).
                if (run_r == RUN_MAX) begin
                    to_s = '0;
                end else if (to_r == TO_LAST) begin
                    state_s = ST_SEARCH;
                    run_s   = '0;
                    to_s    = '0;
                end else begin
                    to_s = to_r + TO_W'(1);
                end
            end
            default: begin
                state_s = ST_SEARCH;
                run_s   = '0;
                to_s    = '0;
                wait_s  = '0;
            end
        endcase
    end

    // Output values for the coming cycle. They follow the next state so that
    // the word completing the run is the first ungated one, and lock loss
    // gates outputs on the same edge that lock_o falls.
    always_comb begin
        bitslip_s = 1'b0;
        lock_s    = 1'b0;
        data_s    = 8'h00;
        ctrl_s    = 2'b00;
        de_s      = 1'b0;
        if (state_s == ST_LOCKED) begin
            lock_s = 1'b1;
            if (is_tok_s) begin
                ctrl_s = tok_ctrl_s;
            end else begin
                de_s   = 1'b1;
                data_s = dec_data_s;
                ctrl_s = ctrl_r;
            end
        end else begin
            bitslip_s = (state_s == ST_SLIP);
        end
    end

    // FSM state and counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_SEARCH;
            run_r   <= '0;
            to_r    <= '0;
            wait_r  <= '0;
        end else begin
            state_r <= state_s;
            run_r   <= run_s;
            to_r    <= to_s;
            wait_r  <= wait_s;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bitslip_r <= 1'b0;
            lock_r    <= 1'b0;
            data_r    <= 8'h00;
            ctrl_r    <= 2'b00;
            de_r      <= 1'b0;
        end else begin
            bitslip_r <= bitslip_s;
            lock_r    <= lock_s;
            data_r    <= data_s;
            ctrl_r    <= ctrl_s;
            de_r      <= de_s;
        end
    end

    assign bitslip_o = bitslip_r;
    assign lock_o    = lock_r;
    assign data_o    = data_r;
    assign ctrl_o    = ctrl_r;
    assign de_o      = de_r;

endmodule

// File: tb/tb_tmds_decoder.sv
// -----------------------------------------------------------------------------
// tb_tmds_decoder
//
// Directed testbench for tmds_decoder. Inputs are driven 1 ns after each
// rising edge and outputs are sampled at the same point, so every value read
// reflects the word sampled at the edge just passed.
// -----------------------------------------------------------------------------
module tb_tmds_decoder;

    localparam int CTRL_RUN       = 32;
    localparam int SEARCH_TIMEOUT = 4096;
    localparam int SLIP_WAIT      = 8;
    localparam int T              = SEARCH_TIMEOUT;
    localparam int SPACING        = SEARCH_TIMEOUT + SLIP_WAIT + 1;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [9:0] raw_i = 10'h100;
    logic       bitslip_o;
    logic       lock_o;
    logic [7:0] data_o;
    logic [1:0] ctrl_o;
    logic       de_o;

    int checks = 0;
    int passed = 0;

    tmds_decoder #(
        .CTRL_RUN       (CTRL_RUN),
        .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
        .SLIP_WAIT      (SLIP_WAIT)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .raw_i     (raw_i),
        .bitslip_o (bitslip_o),
        .lock_o    (lock_o),
        .data_o    (data_o),
        .ctrl_o    (ctrl_o),
        .de_o      (de_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        raw_i = 10'h100;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // Blanking tokens followed by active video, 800 words per line.
    function automatic logic [9:0] stream_word(input int idx);
        if ((idx % 800) < 160) return 10'h354;
        else return 10'h0F0;
    endfunction

    task automatic test_reset();
        int pulses;
        rst_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            raw_i = 10'($urandom_range(1023, 0));
            tick();
            checks++;
            if ({bitslip_o, lock_o, data_o, ctrl_o, de_o} !== 13'd0) begin
                $display("FAIL reset_outputs: got %h expected 0000",
                         {bitslip_o, lock_o, data_o, ctrl_o, de_o});
            end else passed++;
        end
        rst_i  = 1'b0;
        raw_i  = 10'h100;
        pulses = 0;
        for (int k = 1; k < T; k++) begin
            tick();
            if (bitslip_o) pulses++;
        end
        checks++;
        if (pulses !== 0) $display("FAIL reset_no_early_slip: got %0d pulses expected 0", pulses);
        else passed++;
        tick();
        checks++;
        if (bitslip_o !== 1'b1) $display("FAIL reset_first_slip: got %b expected 1", bitslip_o);
        else passed++;
        tick();
        checks++;
        if (bitslip_o !== 1'b0) $display("FAIL slip_one_cycle: got %b expected 0", bitslip_o);
        else passed++;
    endtask

    task automatic test_aligned_lock();
        logic [9:0] dv [5]  = '{10'h0FF, 10'h2AA, 10'h1AA, 10'h0F0, 10'h3C3};
        logic [7:0] dex [5] = '{8'hFF, 8'h01, 8'hFE, 8'hEE, 8'h44};
        do_reset();
        for (int j = 1; j <= 40; j++) begin
            raw_i = 10'h354;
            tick();
            if (j == 31) begin
                checks++;
                if (lock_o !== 1'b0) $display("FAIL lock_early: got %b expected 0", lock_o);
                else passed++;
            end
            if (j == 32) begin
                checks++;
                if ({lock_o, de_o, ctrl_o, data_o} !== {1'b1, 1'b0, 2'b00, 8'h00})
                    $display("FAIL lock_at_run: got %h expected %h",
                             {lock_o, de_o, ctrl_o, data_o}, {1'b1, 1'b0, 2'b00, 8'h00});
                else passed++;
            end
        end
        raw_i = 10'h100;
        tick();
        checks++;
        if ({lock_o, de_o, data_o} !== {1'b1, 1'b1, 8'h00})
            $display("FAIL first_data: got lock=%b de=%b data=%h expected 1 1 00", lock_o, de_o, data_o);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            raw_i = dv[i];
            tick();
            checks++;
            if ({de_o, data_o} !== {1'b1, dex[i]})
                $display("FAIL data_decode[%0d]: raw %h got de=%b data=%h expected de=1 data=%h",
                         i, dv[i], de_o, data_o, dex[i]);
            else passed++;
        end
    endtask

    task automatic test_control_decode();
        logic [9:0] tv [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
        for (int i = 0; i < 4; i++) begin
            raw_i = tv[i];
            tick();
            checks++;
            if ({lock_o, de_o, ctrl_o, data_o} !== {1'b1, 1'b0, 2'(i), 8'h00})
                $display("FAIL ctrl_decode[%0d]: got lock=%b de=%b ctrl=%b data=%h expected 1 0 %b 00",
                         i, lock_o, de_o, ctrl_o, data_o, 2'(i));
            else passed++;
        end
        raw_i = 10'h0FF;
        tick();
        checks++;
        if ({de_o, ctrl_o, data_o} !== {1'b1, 2'b11, 8'hFF})
            $display("FAIL ctrl_hold: got de=%b ctrl=%b data=%h expected 1 11 ff", de_o, ctrl_o, data_o);
        else passed++;
    endtask

    task automatic test_async_reset();
        // Outputs currently show locked pixel data; reset must clear them
        // without waiting for a clock edge.
        rst_i = 1'b1;
        #1;
        checks++;
        if ({bitslip_o, lock_o, data_o, ctrl_o, de_o} !== 13'd0)
            $display("FAIL async_reset: got %h expected 0000", {bitslip_o, lock_o, data_o, ctrl_o, de_o});
        else passed++;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_lock_loss();
        int drops;
        int pulses;
        do_reset();
        for (int j = 1; j <= CTRL_RUN; j++) begin
            raw_i = 10'h354;
            tick();
        end
        checks++;
        if (lock_o !== 1'b1) $display("FAIL loss_prelock: got %b expected 1", lock_o);
        else passed++;
        raw_i = 10'h0FF;
        drops = 0;
        for (int d = 1; d <= T; d++) begin
            tick();
            if (lock_o !== 1'b1) drops++;
        end
        checks++;
        if (drops !== 0 || {de_o, data_o} !== {1'b1, 8'hFF})
            $display("FAIL loss_hold: got %0d early drops de=%b data=%h expected 0 drops de=1 data=ff",
                     drops, de_o, data_o);
        else passed++;
        tick();
        checks++;
        if ({lock_o, de_o, ctrl_o, data_o, bitslip_o} !== 13'd0)
            $display("FAIL loss_gate: got lock=%b de=%b ctrl=%b data=%h slip=%b expected all 0",
                     lock_o, de_o, ctrl_o, data_o, bitslip_o);
        else passed++;
        pulses = 0;
        for (int k = 1; k < T; k++) begin
            tick();
            if (bitslip_o) pulses++;
        end
        tick();
        checks++;
        if (pulses !== 0 || bitslip_o !== 1'b1)
            $display("FAIL loss_next_slip: got %0d early pulses slip=%b expected 0 and 1", pulses, bitslip_o);
        else passed++;
    endtask

    task automatic test_misalign_recovery();
        int         s;
        int         k;
        int         pulses;
        logic       locked;
        logic [19:0] cat;
        do_reset();
        s      = 3;
        k      = 0;
        pulses = 0;
        locked = 1'b0;
        for (int c = 1; c <= 6 * T && !locked; c++) begin
            cat   = {stream_word(k + 1), stream_word(k)};
            raw_i = cat[s +: 10];
            tick();
            k++;
            if (bitslip_o) begin
                pulses++;
                checks++;
                if (c !== T + (pulses - 1) * SPACING)
                    $display("FAIL slip_timing[%0d]: got cycle %0d expected %0d",
                             pulses, c, T + (pulses - 1) * SPACING);
                else passed++;
                s = (s == 0) ? 9 : s - 1;
            end
            if (lock_o) locked = 1'b1;
        end
        checks++;
        if (locked !== 1'b1 || pulses !== 3 || s !== 0)
            $display("FAIL misalign_lock: got lock=%b pulses=%0d offset=%0d expected 1 3 0", locked, pulses, s);
        else passed++;
        checks++;
        if ({de_o, ctrl_o, data_o} !== {1'b0, 2'b00, 8'h00})
            $display("FAIL misalign_token: got de=%b ctrl=%b data=%h expected 0 00 00", de_o, ctrl_o, data_o);
        else passed++;
    endtask

    task automatic test_reset_mid_wait();
        int pulses;
        do_reset();
        raw_i = 10'h0F0;
        for (int c = 1; c <= T; c++) tick();
        checks++;
        if (bitslip_o !== 1'b1) $display("FAIL wait_setup_slip: got %b expected 1", bitslip_o);
        else passed++;
        tick();
        tick();
        rst_i = 1'b1;
        #1;
        checks++;
        if ({bitslip_o, lock_o, data_o, ctrl_o, de_o} !== 13'd0)
            $display("FAIL wait_reset_outputs: got %h expected 0000", {bitslip_o, lock_o, data_o, ctrl_o, de_o});
        else passed++;
        tick();
        tick();
        rst_i  = 1'b0;
        pulses = 0;
        for (int k = 1; k < T; k++) begin
            tick();
            if (bitslip_o) pulses++;
        end
        tick();
        checks++;
        if (pulses !== 0 || bitslip_o !== 1'b1)
            $display("FAIL wait_reset_restart: got %0d early pulses slip=%b expected 0 and 1", pulses, bitslip_o);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_aligned_lock();
        test_control_decode();
        test_async_reset();
        test_lock_loss();
        test_misalign_recovery();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/tmds_decoder.md
# tmds_decoder

Per-channel TMDS receive decoder and word aligner for the DVI input path. It is the receive-side counterpart of the OSERDES-based TMDS transmitter. It takes the 10-bit parallel word delivered each pixel clock by an external 1:10 deserializer and drives that deserializer's bitslip until control-token runs in blanking show correct word alignment. Once aligned, it decodes each word to 8-bit pixel data or 2-bit control and reports lock; the video capture logic consumes its outputs.

## Interface
Parameters:
- CTRL_RUN, 32: consecutive control tokens that prove alignment.
- SEARCH_TIMEOUT, 4096: cycles without a qualifying run before slip (SEARCH) or lock loss (LOCKED). Must exceed one video line.
- SLIP_WAIT, 8: settle cycles after each bitslip pulse.

Ports:
- clk_i, in, 1: pixel clock, also the deserializer CLKDIV.
- rst_i, in, 1: reset. One clock; reset is asynchronous and active-high.
- raw_i, in, 10: deserialized word. raw_i[0] is the first bit on the wire.
- bitslip_o, out, 1: one-cycle bitslip request to the deserializer.
- lock_o, out, 1: word alignment established.
- data_o, out, 8: decoded pixel byte.
- ctrl_o, out, 2: decoded control bits {c1,c0}.
- de_o, out, 1: data enable (word is not a control token).

## Operation
- Token match, combinational on raw_i:
  - 10'b1101010100 → 00
  - 10'b0010101011 → 01
  - 10'b0101010100 → 10
  - 10'b1010101011 → 11
  - Any other word is data (DVI only; no TERC4 or guard-band handling).
- Data decode:
  - m = raw_i[9] ? ~raw_i[7:0] : raw_i[7:0].
  - d[0] = m[0].
  - d[i] = raw_i[8] ? m[i]^m[i-1] : ~(m[i]^m[i-1]) for i = 1..7.
- Counters:
  - run_cnt counts consecutive control tokens and saturates at CTRL_RUN.
  - to_cnt is the timeout counter.
  - Widths are $clog2(param+1).
- FSM states: SEARCH, SLIP, WAIT, LOCKED. Reset state is SEARCH.
- SEARCH:
  - run_cnt increments on a token and clears on data.
  - to_cnt increments every cycle.
  - When run_cnt reaches CTRL_RUN, go to LOCKED and clear to_cnt.
  - Otherwise, when to_cnt reaches SEARCH_TIMEOUT-1, go to SLIP.
  - If both happen in the same cycle, LOCKED wins.
- SLIP: bitslip_o = 1 for exactly one cycle, then go to WAIT.
- WAIT:
  - Hold for SLIP_WAIT cycles, ignoring raw_i.
  - Then go to SEARCH with run_cnt and to_cnt cleared.
- LOCKED:
  - run_cnt behaves as in SEARCH.
  - to_cnt increments each cycle and clears on any cycle where run_cnt == CTRL_RUN.
  - When to_cnt reaches SEARCH_TIMEOUT-1, go to SEARCH with counters cleared. No slip is issued on lock loss.
- Slips repeat without limit. The deserializer wraps after 10 slips.
- Output gating: while the state is not LOCKED, data_o, ctrl_o and de_o are forced to 0.

## Timing
- Reset values (asserted asynchronously): bitslip_o 0, lock_o 0, data_o 0, ctrl_o 0, de_o 0.
- All outputs are registered.
- Decode latency: 1 cycle. The raw_i sampled at edge n appears on data_o/ctrl_o/de_o after edge n.
- Token outputs: de_o 0, ctrl_o = decoded bits, data_o 0.
- Data outputs: de_o 1, data_o = d, ctrl_o holds its last control value.
- Lock acquisition: lock_o rises on the edge at which the CTRL_RUN-th consecutive token is sampled. The outputs for that word are the first ungated ones.
- Slip cadence: from entering SEARCH, bitslip_o pulses SEARCH_TIMEOUT cycles later. After that, pulses are spaced exactly SEARCH_TIMEOUT + SLIP_WAIT + 1 cycles.
- Lock loss: lock_o falls on the same edge where the outputs become gated.
- Reset mid-operation: all state clears immediately, including an in-flight bitslip_o pulse. Operation restarts in SEARCH on the first edge after rst_i deasserts.

## Test plan
- Reset: hold rst_i with random raw_i → all outputs 0. Release → no bitslip_o for SEARCH_TIMEOUT cycles.
- Aligned lock: 40 words of 10'h354 (token 00) then 10'h100 → lock_o 1 after the 32nd token. data_o = 8'h00 and de_o = 1 one cycle after 10'h100 is applied.
- Control decode: while locked, apply 10'h354, 10'h0AB, 10'h154, 10'h2AB → ctrl_o 00, 01, 10, 11, each with de_o 0.
- Misalignment recovery:
  - Bench deserializer model rotates the word by 1 bit per bitslip_o; start misaligned by 3.
  - Stimulus: repeating frame of 160 blanking tokens and 640 data words.
  - Required: exactly the number of pulses needed to rotate back to alignment, pulses spaced SEARCH_TIMEOUT+SLIP_WAIT+1, then lock_o 1.
- Lock loss: after lock, apply only data words → lock_o 0 after 4096 cycles, outputs gated, next bitslip_o 4096 cycles later.
- Reset mid-WAIT: assert rst_i two cycles after a bitslip_o pulse → outputs 0 immediately. After release, the first pulse comes a full SEARCH_TIMEOUT later.
